// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcode, ALUOp, state and op-class definitions for the multicycle sequencer
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        ADDR,
        MEM,
        WB,
        BRANCH,
        TRAP
    } mc_state_t;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } op_class_t;

endpackage

// File: rtl/op_class_decode.sv
// rtl/op_class_decode.sv - combinational opcode to instruction class decode with valid flag
module op_class_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       valid
);

    // Unknown opcodes report CLS_R with valid low so the caller picks trap or R-type execution.
    always_comb begin
        cls   = CLS_R;
        valid = 1'b1;
        case (opcode)
            OP_R:      cls = CLS_R;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RISC-V sequencer; ILLEGAL_TRAP_EN enables trapping on unknown opcodes
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             iord,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic             pc_branch,
    output logic             mdr_wr,
    output logic             branch,
    output logic             memtoReg,
    output logic             ALUSrc,
    output logic             reg_wr,
    output logic [1:0]       ALUOp,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret,
    output logic             illegal_op
);

    mc_state_t        state, state_next;
    op_class_t        cls_q, dec_cls;
    logic             dec_valid;
    logic [CNT_W-1:0] cnt;

    op_class_decode u_decode (
        .opcode (opcode),
        .cls    (dec_cls),
        .valid  (dec_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            cls_q <= CLS_R;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE) begin
                cls_q <= dec_valid ? dec_cls : CLS_R;
            end
            if (instr_done) begin
                cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Reset masks every output in the same cycle, including the counter view.
    assign instret = rst ? '0 : cnt;

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        pc_branch  = 1'b0;
        mdr_wr     = 1'b0;
        branch     = 1'b0;
        memtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        reg_wr     = 1'b0;
        ALUOp      = ALU_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_rd = 1'b1;
                    ir_wr  = mem_ready;
                    pc_wr  = mem_ready;
                    if (mem_ready) state_next = DECODE;
                end
                DECODE: begin
                    case (dec_cls)
                        CLS_LOAD, CLS_STORE: state_next = ADDR;
                        CLS_BRANCH:          state_next = BRANCH;
                        default: begin
`ifdef ILLEGAL_TRAP_EN
                            state_next = dec_valid ? EXEC : TRAP;
`else
                            state_next = EXEC;
`endif
                        end
                    endcase
                end
                EXEC: begin
                    ALUOp      = ALU_FUNCT;
                    reg_wr     = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                ADDR: begin
                    ALUSrc     = 1'b1;
                    state_next = MEM;
                end
                MEM: begin
                    iord   = 1'b1;
                    ALUSrc = 1'b1;
                    mem_rd = (cls_q == CLS_LOAD);
                    mem_wr = (cls_q == CLS_STORE);
                    if (mem_ready) begin
                        mdr_wr     = (cls_q == CLS_LOAD);
                        instr_done = (cls_q == CLS_STORE);
                        state_next = (cls_q == CLS_LOAD) ? WB : FETCH;
                    end
                end
                WB: begin
                    memtoReg   = 1'b1;
                    reg_wr     = 1'b1;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                BRANCH: begin
                    branch     = 1'b1;
                    ALUOp      = ALU_SUB;
                    pc_branch  = zero;
                    instr_done = 1'b1;
                    state_next = FETCH;
                end
                TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                    illegal_op = 1'b1;
`endif
                    state_next = TRAP;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control against a per-class cycle model
module tb_multicycle_control;

    localparam int CW = 4;

    localparam logic [6:0] T_R      = 7'b0110011;
    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    // Control vector bit positions, mirroring the port order below.
    localparam logic [14:0] C_RD   = 15'd1 << 14;
    localparam logic [14:0] C_WR   = 15'd1 << 13;
    localparam logic [14:0] C_IORD = 15'd1 << 12;
    localparam logic [14:0] C_IRW  = 15'd1 << 11;
    localparam logic [14:0] C_PCW  = 15'd1 << 10;
    localparam logic [14:0] C_PCB  = 15'd1 << 9;
    localparam logic [14:0] C_MDR  = 15'd1 << 8;
    localparam logic [14:0] C_BR   = 15'd1 << 7;
    localparam logic [14:0] C_M2R  = 15'd1 << 6;
    localparam logic [14:0] C_SRC  = 15'd1 << 5;
    localparam logic [14:0] C_RW   = 15'd1 << 4;
    localparam logic [14:0] A_SUB  = 15'd1 << 2;
    localparam logic [14:0] A_FN   = 15'd2 << 2;
    localparam logic [14:0] C_DONE = 15'd1 << 1;
    localparam logic [14:0] C_ILL  = 15'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = T_R;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_rd, mem_wr, iord, ir_wr, pc_wr, pc_branch, mdr_wr;
    logic          branch, memtoReg, ALUSrc, reg_wr, instr_done, illegal_op;
    logic [1:0]    ALUOp;
    logic [CW-1:0] instret;
    logic [14:0]   ctl;

    int            vecs = 0;
    int            errs = 0;
    logic [CW-1:0] exp_cnt = '0;
    string         cur_test = "init";

    multicycle_control #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .iord       (iord),
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .pc_branch  (pc_branch),
        .mdr_wr     (mdr_wr),
        .branch     (branch),
        .memtoReg   (memtoReg),
        .ALUSrc     (ALUSrc),
        .reg_wr     (reg_wr),
        .ALUOp      (ALUOp),
        .instr_done (instr_done),
        .instret    (instret),
        .illegal_op (illegal_op)
    );

    assign ctl = {mem_rd, mem_wr, iord, ir_wr, pc_wr, pc_branch, mdr_wr,
                  branch, memtoReg, ALUSrc, reg_wr, ALUOp, instr_done, illegal_op};

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_cycle(input logic mr, input logic [14:0] e);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = mr;
        #1;
        vecs++;
        if ({ctl, instret} !== {e, exp_cnt}) begin
            errs++;
            $display("FAIL %s: ctl=%h instret=%0d, expected ctl=%h instret=%0d",
                     cur_test, ctl, instret, e, exp_cnt);
        end
        if (e[1]) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = rb();
        #1;
        vecs++;
        if ({ctl, instret} !== '0) begin
            errs++;
            $display("FAIL %s reset: ctl=%h instret=%0d, expected all zero", cur_test, ctl, instret);
        end
        exp_cnt = '0;
    endtask

    // Expected cycle sequence for one instruction, built from the class rules.
    task automatic run_instr(input logic [6:0] o, input logic z, input int fw, input int mw);
        opcode = o;
        zero   = z;
        for (int i = 0; i < fw; i++) do_cycle(1'b0, C_RD);
        do_cycle(1'b1, C_RD | C_IRW | C_PCW);
        do_cycle(rb(), '0);
        case (o)
            T_LOAD: begin
                do_cycle(rb(), C_SRC);
                for (int i = 0; i < mw; i++) do_cycle(1'b0, C_IORD | C_SRC | C_RD);
                do_cycle(1'b1, C_IORD | C_SRC | C_RD | C_MDR);
                do_cycle(rb(), C_M2R | C_RW | C_DONE);
            end
            T_STORE: begin
                do_cycle(rb(), C_SRC);
                for (int i = 0; i < mw; i++) do_cycle(1'b0, C_IORD | C_SRC | C_WR);
                do_cycle(1'b1, C_IORD | C_SRC | C_WR | C_DONE);
            end
            T_BRANCH: do_cycle(rb(), C_BR | A_SUB | C_DONE | (z ? C_PCB : 15'd0));
            T_R:      do_cycle(rb(), A_FN | C_RW | C_DONE);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++) do_cycle(rb(), C_ILL);
`else
                do_cycle(rb(), A_FN | C_RW | C_DONE);
`endif
            end
        endcase
    endtask

    task automatic test_reset();
        cur_test = "reset";
        reset_cycle();
        reset_cycle();
    endtask

    task automatic test_rtype();
        cur_test = "rtype";
        run_instr(T_R, rb(), 0, 0);
        do_cycle(1'b0, C_RD);
    endtask

    task automatic test_load_waits();
        cur_test = "load_waits";
        run_instr(T_LOAD, rb(), 2, 2);
    endtask

    task automatic test_store_branch();
        cur_test = "store";
        run_instr(T_STORE, rb(), 0, 0);
        cur_test = "branch_taken";
        run_instr(T_BRANCH, 1'b1, 0, 0);
        cur_test = "branch_not_taken";
        run_instr(T_BRANCH, 1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_load();
        cur_test = "reset_mid_load";
        reset_cycle();
        opcode = T_LOAD;
        do_cycle(1'b1, C_RD | C_IRW | C_PCW);
        do_cycle(1'b0, '0);
        do_cycle(1'b0, C_SRC);
        reset_cycle();
        do_cycle(1'b0, C_RD);
        run_instr(T_R, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        cur_test = "illegal_opcode";
        run_instr(T_BAD, rb(), 1, 0);
`ifdef ILLEGAL_TRAP_EN
        reset_cycle();
`endif
        run_instr(T_R, 1'b0, 0, 0);
    endtask

    task automatic test_wrap();
        cur_test = "counter_wrap";
        reset_cycle();
        for (int i = 0; i < 16; i++) run_instr(T_R, 1'b0, 0, 0);
        do_cycle(1'b0, C_RD);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [5];
        cur_test = "random_stream";
        ops[0] = T_R; ops[1] = T_LOAD; ops[2] = T_STORE; ops[3] = T_BRANCH; ops[4] = T_BAD;
        for (int n = 0; n < 30; n++) begin
`ifdef ILLEGAL_TRAP_EN
            run_instr(ops[$urandom_range(0, 3)], rb(), $urandom_range(0, 2), $urandom_range(0, 2));
`else
            run_instr(ops[$urandom_range(0, 4)], rb(), $urandom_range(0, 2), $urandom_range(0, 2));
`endif
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_waits();
        test_store_branch();
        test_reset_mid_load();
        test_illegal();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the RISC-V datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables, ALU controls and a single shared memory port with a ready handshake. It supports R-type, load, store and branch instructions, counts retired instructions, and optionally traps on unsupported opcodes.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  opcode field from the instruction register; stable except in the cycle after ir_wr.
- zero  in  1  ALU zero flag (branch condition).
- mem_ready  in  1  memory completes the current mem_rd/mem_wr access in this cycle.
- mem_rd, mem_wr  out  1  memory read/write request, held until mem_ready.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- ir_wr  out  1  load instruction register (also captures old PC in datapath).
- pc_wr  out  1  PC <= PC+4.
- pc_branch  out  1  PC <= branch target.
- mdr_wr  out  1  capture memory read data.
- branch, memtoReg, ALUSrc, reg_wr  out  1  datapath controls, same meaning as single-cycle decode.
- ALUOp  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- instr_done  out  1  single-cycle pulse in the last cycle of each instruction.
- instret  out  CNT_W  retired-instruction count.
- illegal_op  out  1  sticky trap flag (only with ILLEGAL_TRAP_EN; otherwise tied 0).

## Operation
- Opcode classes: R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- The class is registered in DECODE and used by later states.
- Outputs not listed for a state are 0.
- States and transitions:
  - FETCH: mem_rd=1, iord=0. Stays in FETCH while mem_ready=0. When mem_ready=1: ir_wr=1, pc_wr=1, next state DECODE.
  - DECODE: classify opcode. R -> EXEC; LOAD/STORE -> ADDR; BRANCH -> BRANCH; other -> TRAP (macro on) or EXEC (macro off).
  - EXEC: ALUSrc=0, ALUOp=10, reg_wr=1, memtoReg=0, instr_done=1. Next state FETCH.
  - ADDR: ALUSrc=1, ALUOp=00. Next state MEM.
  - MEM: iord=1, ALUSrc=1, ALUOp=00; mem_rd=1 for a load, mem_wr=1 for a store. Stays in MEM while mem_ready=0. When mem_ready=1:
    - load: mdr_wr=1, next state WB.
    - store: instr_done=1, next state FETCH.
  - WB: memtoReg=1, reg_wr=1, instr_done=1. Next state FETCH.
  - BRANCH: branch=1, ALUSrc=0, ALUOp=01, pc_branch=zero, instr_done=1. Next state FETCH.
  - TRAP: all controls 0, illegal_op=1. Exits only on rst.
- Counter: instret increments by 1 when instr_done=1 and wraps from 2^CNT_W-1 to 0.
- Handshake rules:
  - A request stays asserted, with address select unchanged, until mem_ready=1.
  - mem_ready is ignored in states with no request.
  - mem_rd and mem_wr are never asserted together.

## Timing
- Reset:
  - While rst=1, every output is forced 0 combinationally.
  - Next state is FETCH, instret <= 0, class register <= R.
  - First cycle after release: mem_rd=1, iord=0.
- Reset mid-instruction aborts the instruction immediately. The outstanding request drops and instret is not incremented.
- Latency with zero-wait memory (mem_ready=1 on first request cycle): R 3 cycles, branch 3, store 4, load 5. Each mem_ready=0 cycle adds one.
- ir_wr, pc_wr and mdr_wr are Mealy (gated by mem_ready). All other controls are Moore, decoded from the state.
- pc_wr and pc_branch are never asserted in the same cycle.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE goes to TRAP.
  - illegal_op rises in the first TRAP cycle and stays high until rst.
  - No further fetches occur and instret freezes.
- ILLEGAL_TRAP_EN undefined:
  - An unknown opcode executes as R-type (EXEC) and retires normally.
  - illegal_op is tied 0.

## Structure
- Shared package riscv_pkg:
  - opcode constants OP_R, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALUOp constants ALU_ADD, ALU_SUB, ALU_FUNCT;
  - state enum mc_state_t with FETCH, DECODE, EXEC, ADDR, MEM, WB, BRANCH, TRAP (3 bits);
  - op class enum op_class_t.
- Sub-module op_class_decode: combinational opcode -> op_class_t plus valid bit. The FSM, output decode and counter stay in multicycle_control.

## Test plan
- Reset, then R-type (0110011) with mem_ready=1 every cycle -> states FETCH, DECODE, EXEC; reg_wr=1 only in cycle 3; instr_done pulse; instret=1.
- Load (0000011) with mem_ready low for 2 cycles in both FETCH and MEM -> mem_rd held 3 cycles each; iord=0 then 1; mdr_wr and WB follow; total 9 cycles; instret +1.
- Store (0100011) then branch (1100011) with zero=1, then the same branch with zero=0:
  - store: mem_wr=1 in MEM, reg_wr never asserted;
  - branch: pc_branch=1 then 0; pc_wr seen only in FETCH.
- rst asserted in the MEM wait cycle of a load -> all outputs 0 that cycle; next cycle FETCH with mem_rd=1; instret unchanged at 0.
- Opcode 1111111:
  - macro on: TRAP, illegal_op=1 sticky, no mem_rd for 10 cycles;
  - macro off: executes as R-type, instret +1.
- CNT_W=4, 16 R-type instructions -> instret wraps to 0.
